// File: rtl/ras_ctrl.sv
// Return-address-stack command generator: classifies fetch packets, issues push/pop/replace
// pulses and a registered next-pc prediction. Macro RAS_RVC_EN enables compressed C.JR/C.JALR decode.
module ras_ctrl #(
   parameter int ras_size = 8,
   localparam int DepthW = $clog2(ras_size + 1)
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [47:0]       in_pc,
   input  logic              flush,
   input  logic [47:0]       ras_top,
   output logic              ras_push,
   output logic              ras_pop,
   output logic              ras_replace,
   output logic [47:0]       ras_idata,
   output logic              pred_valid,
   input  logic              pred_ready,
   output logic              pred_taken,
   output logic [47:0]       pred_target,
   output logic [1:0]        pred_kind,
   output logic [DepthW-1:0] ras_depth
);

   typedef enum logic [1:0] {
      K_NONE = 2'b00,
      K_CALL = 2'b01,
      K_RET  = 2'b10,
      K_CORO = 2'b11
   } kind_e;

   function automatic logic is_link(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   logic              push_q, push_d, pop_q, pop_d, repl_q, repl_d;
   logic [47:0]       idata_q, idata_d, target_q, target_d;
   logic              pvalid_q, pvalid_d, taken_q, taken_d;
   kind_e             kind_q, kind_d;
   logic [DepthW-1:0] depth_q, depth_d;

   logic              accept_s, c_push, c_pop, c_repl, c_jal;
   logic [47:0]       ret_addr, jimm, top_eff, depth_inc;
   logic [4:0]        rd, rs1;

   assign in_ready = (!pvalid_q || pred_ready) && !pop_q && !flush;
   assign accept_s = in_valid && in_ready;
   assign rd       = in_instr[11:7];
   assign rs1      = in_instr[19:15];
   assign jimm     = {{27{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};
   // A command issued this cycle has not reached the stack yet, so forward its data.
   assign top_eff  = (push_q || repl_q) ? idata_q : ras_top;
   assign depth_inc = 48'(depth_q);

   // Instruction classification into stack actions.
   always_comb begin
      c_push   = 1'b0;
      c_pop    = 1'b0;
      c_repl   = 1'b0;
      c_jal    = 1'b0;
      ret_addr = in_pc + 48'd4;
      if (in_instr[6:0] == 7'b1101111) begin
         c_jal  = is_link(rd);
         c_push = is_link(rd);
      end else if (in_instr[6:0] == 7'b1100111 && in_instr[14:12] == 3'b000) begin
         if (!is_link(rd)) begin
            c_pop = is_link(rs1);
         end else if (!is_link(rs1) || rd == rs1) begin
            c_push = 1'b1;
         end else begin
            c_repl = 1'b1;
         end
      end else begin
`ifdef RAS_RVC_EN
         if (in_instr[1:0] == 2'b10 && in_instr[15:13] == 3'b100 &&
             in_instr[6:2] == 5'd0 && in_instr[11:7] != 5'd0) begin
            ret_addr = in_pc + 48'd2;
            if (in_instr[12]) begin
               c_push = !is_link(in_instr[11:7]) || in_instr[11:7] == 5'd1;
               c_repl = (in_instr[11:7] == 5'd5);
            end else begin
               c_pop = is_link(in_instr[11:7]);
            end
         end else begin
            ret_addr = (in_instr[1:0] != 2'b11) ? in_pc + 48'd2 : in_pc + 48'd4;
         end
`else
         c_push = 1'b0;
`endif
      end
   end

   // Next-state for prediction, stack pulses and occupancy.
   always_comb begin
      push_d   = 1'b0;
      pop_d    = 1'b0;
      repl_d   = 1'b0;
      idata_d  = idata_q;
      pvalid_d = pvalid_q;
      taken_d  = taken_q;
      target_d = target_q;
      kind_d   = kind_q;
      depth_d  = depth_q;
      if (flush) begin
         pvalid_d = 1'b0;
         taken_d  = 1'b0;
         target_d = 48'd0;
         kind_d   = K_NONE;
      end else if (accept_s) begin
         pvalid_d = 1'b1;
         taken_d  = 1'b0;
         target_d = 48'd0;
         kind_d   = K_NONE;
         if (c_push || (c_repl && depth_q == '0)) begin
            kind_d  = c_push ? K_CALL : K_CORO;
            push_d  = 1'b1;
            idata_d = ret_addr;
            if (depth_inc < 48'(ras_size)) begin
               depth_d = depth_q + 1'b1;
            end else begin
               depth_d = depth_q;
            end
            if (c_jal) begin
               taken_d  = 1'b1;
               target_d = in_pc + jimm;
            end else begin
               taken_d  = 1'b0;
            end
         end else if (c_repl) begin
            kind_d   = K_CORO;
            repl_d   = 1'b1;
            idata_d  = ret_addr;
            taken_d  = 1'b1;
            target_d = top_eff;
         end else if (c_pop) begin
            kind_d = K_RET;
            if (depth_q != '0) begin
               pop_d    = 1'b1;
               taken_d  = 1'b1;
               target_d = top_eff;
               depth_d  = depth_q - 1'b1;
            end else begin
               pop_d    = 1'b0;
            end
         end else begin
            kind_d = K_NONE;
         end
      end else if (pred_ready) begin
         pvalid_d = 1'b0;
      end else begin
         pvalid_d = pvalid_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         push_q   <= 1'b0;
         pop_q    <= 1'b0;
         repl_q   <= 1'b0;
         idata_q  <= 48'd0;
         pvalid_q <= 1'b0;
         taken_q  <= 1'b0;
         target_q <= 48'd0;
         kind_q   <= K_NONE;
         depth_q  <= '0;
      end else begin
         push_q   <= push_d;
         pop_q    <= pop_d;
         repl_q   <= repl_d;
         idata_q  <= idata_d;
         pvalid_q <= pvalid_d;
         taken_q  <= taken_d;
         target_q <= target_d;
         kind_q   <= kind_d;
         depth_q  <= depth_d;
      end
   end

   assign ras_push    = push_q;
   assign ras_pop     = pop_q;
   assign ras_replace = repl_q;
   assign ras_idata   = idata_q;
   assign pred_valid  = pvalid_q;
   assign pred_taken  = taken_q;
   assign pred_target = target_q;
   assign pred_kind   = kind_q;
   assign ras_depth   = depth_q;

endmodule
